lcd_hd44780_ctrl: RTL

- Dedicated HD44780 character-LCD write controller (8-bit bus, write-only), directly downstream of the clock/display formatter.
- After power-up it runs the fixed init sequence itself, then accepts one command or data byte per valid/ready handshake.
- For each byte it generates the RS/EN/data timing and the post-write execution wait, so upstream logic only presents bytes.

---
 rtl/lcd_hd44780_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_ctrl
//
// Write-only controller for an HD44780 character LCD on an 8-bit bus.
// After reset it waits out the LCD power-up time, sends the fixed init
// sequence (function set, display on, clear, entry mode), then accepts one
// command or data byte per valid/ready handshake. For every byte it produces
// the setup / EN pulse / hold timing and the post-write execution wait.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   req_valid    upstream byte available
//   req_rs       0 = command, 1 = character data
//   req_data     byte to write
//   req_ready    controller accepts a byte this cycle
//   init_done    init sequence complete, sticky until rst
//   LCD_DataBus  LCD data bus
//   LCD_RS       register select
//   LCD_RW       read/write, constant 0 (write-only)
//   LCD_EN       enable strobe
//   LCD_ON       LCD power/backlight enable
//   dbg_state    current FSM state, for observation only
//
// Handshake: a byte is transferred on every rising clk edge where
// req_valid and req_ready are both 1. req_ready is high only in IDLE and
// does not depend on req_valid. While req_ready is low, req_valid is
// ignored and nothing is buffered; upstream keeps the request asserted
// until the transfer edge. req_data/req_rs are registered at that edge,
// so later changes do not affect the byte in flight.
// ---------------------------------------------------------------------------
module lcd_hd44780_ctrl #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 20,
    parameter int unsigned EN_HIGH_CYC = 75,
    parameter int unsigned HOLD_CYC    = 20,
    parameter int unsigned EXEC_CYC    = 2500,
    parameter int unsigned CLEAR_CYC   = 85000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic [7:0] LCD_DataBus,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_PWRUP     = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_PULSE     = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_EXEC      = 3'd5;
    localparam logic [2:0] S_IDLE      = 3'd6;

    // Counter is sized for the longest of all timed states.
    localparam int unsigned MAX_A = (POWERUP_CYC > SETUP_CYC)   ? POWERUP_CYC : SETUP_CYC;
    localparam int unsigned MAX_B = (MAX_A       > EN_HIGH_CYC) ? MAX_A       : EN_HIGH_CYC;
    localparam int unsigned MAX_C = (MAX_B       > HOLD_CYC)    ? MAX_B       : HOLD_CYC;
    localparam int unsigned MAX_D = (MAX_C       > EXEC_CYC)    ? MAX_C       : EXEC_CYC;
    localparam int unsigned MAX_E = (MAX_D       > CLEAR_CYC)   ? MAX_D       : CLEAR_CYC;
    localparam int unsigned CNT_W = $clog2(MAX_E) + 1;

    // Reload values: a state of length N is entered with N-1 and left at 0.
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [7:0]       bus_q, bus_d;
    logic             rs_q, rs_d;
    logic             en_q;
    logic             ready_q;
    logic             on_q;
    logic             cnt_zero;
    logic             long_wait;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;  // function set: 8-bit, 2 lines, 5x8
            2'd1:    init_rom = 8'h0E;  // display on, cursor on
            2'd2:    init_rom = 8'h01;  // clear display
            default: init_rom = 8'h06;  // entry mode: increment, no shift
        endcase
    endfunction

    assign cnt_zero = (cnt_q == '0);

    // Clear and return-home need the long execution wait.
    assign long_wait = !rs_q && ((bus_q == 8'h01) || (bus_q == 8'h02) || (bus_q == 8'h03));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        bus_d   = bus_q;
        rs_d    = rs_q;
        case (state_q)
            S_PWRUP: begin
                // on_q is still 0 on the first edge after rst is released:
                // that edge arms the power-up count, so PWRUP spans
                // POWERUP_CYC cycles with LCD_ON high.
                if (!on_q) begin
                    cnt_d = LD_PWRUP;
                end else if (cnt_zero) begin
                    state_d = S_INIT_LOAD;
                    idx_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_INIT_LOAD: begin
                bus_d   = init_rom(idx_q);
                rs_d    = 1'b0;
                state_d = S_SETUP;
                cnt_d   = LD_SETUP;
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_EXEC;
                    cnt_d   = long_wait ? LD_CLEAR : LD_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_EXEC: begin
                if (cnt_zero) begin
                    if (done_q) begin
                        state_d = S_IDLE;
                    end else if (idx_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_INIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    bus_d   = req_data;
                    rs_d    = req_rs;
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    // EN and ready are registered from the next state so they line up
    // exactly with the state they belong to and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            bus_q   <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
            rs_q    <= rs_d;
            en_q    <= (state_d == S_PULSE);
            ready_q <= (state_d == S_IDLE);
            on_q    <= 1'b1;
        end
    end

    assign req_ready   = ready_q;
    assign init_done   = done_q;
    assign LCD_DataBus = bus_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = 1'b0;
    assign LCD_EN      = en_q;
    assign LCD_ON      = on_q;
    assign dbg_state   = state_q;

endmodule
